sys_bridge_n: RTL and testbench
===============================

// Module: sys_bridge_n
// PURPOSE
//   Parametrised CPU-to-peripheral system bridge for N_DEV memory-mapped devices, each in a 16-byte window.
//   Sits between the CPU data-memory port and the timer/IO devices; replaces the fixed 3-device bridge.
//   Adds a registered request/ready handshake with device acknowledge, a bus-error response and registered interrupt routing.
// PARAMETERS
//   N_DEV     3             number of device slots (1..16); slot i decodes PrAddr[31:4] == BASE_TAG+i
//   BASE_TAG  28'h00007F0   address tag (PrAddr[31:4]) of slot 0
//   TIMEOUT   16            ACCESS cycles without DEV_Ack before bus error (BRIDGE_TIMEOUT_EN only); >=1
// PORTS
//   clk          in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-high reset
//   PrReq        in   1         CPU access request (sampled only in IDLE)
//   PrAddr       in   32        CPU byte address
//   PrWe         in   1         1 = write, 0 = read
//   PrDout       in   32        CPU write data
//   PrDin        out  32        registered read data to CPU
//   PrReady      out  1         one-cycle pulse: access complete
//   PrErr        out  1         qualifies PrReady: access failed (decode miss or timeout)
//   HWInt        out  6         registered interrupt lines to CP0
//   DEV_Addr     out  32        latched address to devices
//   DEV_WD       out  32        latched write data to devices
//   DEV_Sel      out  N_DEV     one-hot device select, high for the whole ACCESS state
//   DEV_We       out  1         write strobe, high only on first ACCESS cycle of a write
//   DEV_RD       in   32*N_DEV  flattened device read data, slot i at [32*i+31:32*i]
//   DEV_Ack      in   N_DEV     device acknowledge, slot i valid only while DEV_Sel[i]
//   DEV_IRQ      in   N_DEV     level interrupt requests, synchronous to clk
// BEHAVIOUR
//   Reset: state IDLE; PrDin=0, PrReady=0, PrErr=0, HWInt=0, DEV_Addr=0, DEV_WD=0, DEV_Sel=0, DEV_We=0, counter=0.
//   Reset mid-access aborts the access at once; no PrReady is produced for it.
//   FSM states IDLE, ACCESS, DONE:
//   - IDLE: PrReq=1 and hit -> latch PrAddr/PrDout/PrWe, DEV_Sel=onehot(slot), go ACCESS.
//           PrReq=1 and miss -> PrDin<=0, PrErr<=1, go DONE. No device is touched. PrReq=0 -> stay.
//   - ACCESS: DEV_Ack[slot]=1 -> PrDin<=DEV_RD[slot] (0 on writes), PrErr<=0, go DONE.
//             DEV_Ack of non-selected slots is ignored. DEV_We is a single pulse per write access.
//   - DONE: PrReady=1 for exactly this cycle, DEV_Sel=0, go IDLE. PrDin holds until the next DONE.
//   PrReq outside IDLE is ignored. The CPU stalls while PrReq is high and PrReady is low.
//   Latency: request sampled in cycle n, earliest PrReady in cycle n+2 on a hit and n+1 on a miss.
//   Decode: hit iff PrAddr[31:4]-BASE_TAG < N_DEV (28-bit unsigned subtract).
//     A wrap below BASE_TAG is a miss. Slot index is the low bits of that difference.
//   HWInt[i] <= DEV_IRQ[i] for i < min(N_DEV,6); other bits are 0. Latency is 1 cycle.
//     Slots at index 6 or higher are ORed into HWInt[5].
// CONFIGURATION
//   BRIDGE_TIMEOUT_EN defined:
//     counter clears on entering ACCESS and increments each ACCESS cycle without ack.
//     When the counter reaches TIMEOUT: PrDin<=0, PrErr<=1, go DONE.
//     An ack in the same cycle as the timeout wins.
//   Undefined: no counter; ACCESS waits indefinitely for DEV_Ack; PrErr is only raised on a decode miss.
// STRUCTURE
//   Package sys_bridge_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), WIN_LSB=4, data width 32.
//   Sub-module bridge_addr_dec: combinational decoder, PrAddr -> {hit, slot index, one-hot select}.
//   Parametrised by N_DEV/BASE_TAG. Everything else (FSM, latches, counter, IRQ register) stays in sys_bridge_n.
// TESTING
//   Read slot1 with N_DEV=3: PrAddr=0x7F14, PrWe=0, device 1 acks in first ACCESS cycle with RD=0xDEADBEEF.
//     -> DEV_Sel=3'b010; PrReady 2 cycles after request; PrDin=0xDEADBEEF; PrErr=0.
//   Write slot0: PrAddr=0x7F08, PrDout=0x12345678, ack after 3 cycles.
//     -> DEV_We high 1 cycle; DEV_WD=0x12345678; PrReady on cycle n+5.
//   Decode miss at 0x7F30 and at 0x7EF0 -> no DEV_Sel; PrReady+PrErr on n+1; PrDin=0.
//   Timeout with BRIDGE_TIMEOUT_EN and TIMEOUT=4, slot 2 never acks.
//     -> PrReady+PrErr after 4 ACCESS cycles; PrDin=0.
//     Without the macro, the bench checks the bridge is still in ACCESS after 100 cycles.
//   DEV_IRQ=3'b101 for 1 cycle -> HWInt=6'b000101 one cycle later, then 0.
//     Ack from a non-selected slot is ignored.
//   reset asserted mid-ACCESS -> DEV_Sel=0 immediately, no PrReady.
//     Next request after release completes normally.

Source files
------------

// File: rtl/sys_bridge_pkg.sv
// sys_bridge_pkg: shared state encoding and bus constants for the N-device system bridge
package sys_bridge_pkg;
  localparam int DW = 32;
  localparam int WIN_LSB = 4;
  localparam int TAG_W = 32 - WIN_LSB;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sys_bridge_n_dec.sv
// bridge_addr_dec: maps an address tag onto one of N_DEV consecutive 16-byte device windows
module bridge_addr_dec
  import sys_bridge_pkg::*;
#(
  parameter int               N_DEV    = 3,
  parameter logic [TAG_W-1:0] BASE_TAG = 28'h00007F0
) (
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_hit,
  output logic [3:0]       o_slot,
  output logic [N_DEV-1:0] o_sel
);
  logic [TAG_W-1:0] w_diff;
  // unsigned wrap makes tags below BASE_TAG huge, so one compare covers both ends
  assign w_diff = i_tag - BASE_TAG;
  assign o_hit  = w_diff < TAG_W'(N_DEV);
  assign o_slot = w_diff[3:0];
  assign o_sel  = o_hit ? N_DEV'(1) << o_slot : '0;
endmodule

// File: rtl/sys_bridge_n.sv
// sys_bridge_n: CPU-to-peripheral bridge with request/ack handshake, bus error and IRQ routing.
// Define BRIDGE_TIMEOUT_EN to abort unacknowledged accesses after TIMEOUT cycles.
module sys_bridge_n
  import sys_bridge_pkg::*;
#(
  parameter int               N_DEV    = 3,
  parameter logic [TAG_W-1:0] BASE_TAG = 28'h00007F0,
  parameter int               TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PrReq,
  input  logic [31:0]         PrAddr,
  input  logic                PrWe,
  input  logic [31:0]         PrDout,
  output logic [31:0]         PrDin,
  output logic                PrReady,
  output logic                PrErr,
  output logic [5:0]          HWInt,
  output logic [31:0]         DEV_Addr,
  output logic [31:0]         DEV_WD,
  output logic [N_DEV-1:0]    DEV_Sel,
  output logic                DEV_We,
  input  logic [DW*N_DEV-1:0] DEV_RD,
  input  logic [N_DEV-1:0]    DEV_Ack,
  input  logic [N_DEV-1:0]    DEV_IRQ
);
  state_t           r_state;
  logic             r_we;
  logic [3:0]       r_slot;
  logic             w_hit;
  logic [3:0]       w_slot;
  logic [N_DEV-1:0] w_sel;
  logic             w_ack;
  logic             w_to;
  logic [DW-1:0]    w_rd;
  logic [5:0]       w_irq;
  if (N_DEV < 1 || N_DEV > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("sys_bridge_n: N_DEV must be 1..16 and TIMEOUT >= 1");
  end
  bridge_addr_dec #(.N_DEV(N_DEV), .BASE_TAG(BASE_TAG)) u_dec (
    .i_tag  (PrAddr[31:WIN_LSB]),
    .o_hit  (w_hit),
    .o_slot (w_slot),
    .o_sel  (w_sel)
  );
  // DEV_Sel is one-hot, so acks from other slots are masked out here
  assign w_ack = |(DEV_Ack & DEV_Sel);
  always_comb begin
    w_rd  = '0;
    w_irq = '0;
    for (int i = 0; i < N_DEV; i++) begin
      w_rd = w_rd | ((r_slot == 4'(i)) ? DEV_RD[DW*i +: DW] : '0);
      w_irq[i > 5 ? 5 : i] = w_irq[i > 5 ? 5 : i] | DEV_IRQ[i];
    end
  end
`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0] r_cnt;
  assign w_to = r_cnt == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (r_state == IDLE) r_cnt <= '0;
    else if (r_state == ACCESS && !w_ack) r_cnt <= r_cnt + 16'd1;
  end
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_slot   <= '0;
      PrDin    <= '0;
      PrReady  <= 1'b0;
      PrErr    <= 1'b0;
      HWInt    <= '0;
      DEV_Addr <= '0;
      DEV_WD   <= '0;
      DEV_Sel  <= '0;
      DEV_We   <= 1'b0;
    end else begin
      HWInt <= w_irq;
      case (r_state)
        IDLE: if (PrReq) begin
          if (w_hit) begin
            r_state  <= ACCESS;
            r_we     <= PrWe;
            r_slot   <= w_slot;
            DEV_Addr <= PrAddr;
            DEV_WD   <= PrDout;
            DEV_Sel  <= w_sel;
            DEV_We   <= PrWe;
          end else begin
            r_state <= DONE;
            PrDin   <= '0;
            PrErr   <= 1'b1;
            PrReady <= 1'b1;
          end
        end
        ACCESS: begin
          DEV_We <= 1'b0;
          if (w_ack || w_to) begin
            r_state <= DONE;
            PrDin   <= (w_ack && !r_we) ? w_rd : '0;
            PrErr   <= !w_ack;
            PrReady <= 1'b1;
            DEV_Sel <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          PrReady <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sys_bridge_n.sv
// tb_sys_bridge_n: directed and randomized checks of sys_bridge_n against a window-arithmetic model
module tb_sys_bridge_n;
  localparam int          N  = 3;
  localparam logic [27:0] BT = 28'h00007F0;
  localparam int          TO = 4;
  logic            clk = 1'b0;
  logic            reset;
  logic            PrReq, PrWe;
  logic [31:0]     PrAddr, PrDout, PrDin, DEV_Addr, DEV_WD;
  logic            PrReady, PrErr, DEV_We;
  logic [5:0]      HWInt;
  logic [N-1:0]    DEV_Sel, DEV_Ack, DEV_IRQ;
  logic [32*N-1:0] DEV_RD;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sys_bridge_n #(.N_DEV(N), .BASE_TAG(BT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .PrReq(PrReq), .PrAddr(PrAddr), .PrWe(PrWe), .PrDout(PrDout),
    .PrDin(PrDin), .PrReady(PrReady), .PrErr(PrErr), .HWInt(HWInt), .DEV_Addr(DEV_Addr),
    .DEV_WD(DEV_WD), .DEV_Sel(DEV_Sel), .DEV_We(DEV_We), .DEV_RD(DEV_RD), .DEV_Ack(DEV_Ack),
    .DEV_IRQ(DEV_IRQ)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly, input logic [N-1:0] noise);
    longint a, lo, hi;
    bit hit;
    int slot;
    logic [N-1:0] sel;
    logic [31:0] dexp;
    logic [32*N-1:0] rdv;
    lo = longint'(BT) * 16;
    hi = lo + N * 16;
    a = longint'(addr);
    hit = (a >= lo) && (a < hi);
    slot = hit ? int'((a - lo) / 16) : -1;
    sel = '0;
    if (hit) sel[slot] = 1'b1;
    for (int i = 0; i < N; i++) rdv[32*i +: 32] = (i == slot) ? rd : $urandom;
    dexp = (hit && !we) ? rd : 32'd0;
    PrReq = 1'b1; PrAddr = addr; PrWe = we; PrDout = wd; DEV_RD = rdv;
    @(negedge clk);
    PrReq = 1'b0; PrAddr = $urandom; PrDout = $urandom; PrWe = 1'($urandom);
    if (hit) begin
      for (int k = 0; k <= dly; k++) begin
        chk("sel", 32'(DEV_Sel), 32'(sel));
        chk("dev_we", 32'(DEV_We), 32'(we && k == 0));
        chk("dev_addr", DEV_Addr, addr);
        if (we) chk("dev_wd", DEV_WD, wd);
        chk("rdy_early", 32'(PrReady), 32'd0);
        DEV_Ack = (k == dly) ? (sel | (noise & ~sel)) : (noise & ~sel);
        @(negedge clk);
      end
      DEV_Ack = '0;
    end
    chk("rdy", 32'(PrReady), 32'd1);
    chk("err", 32'(PrErr), 32'(!hit));
    chk("din", PrDin, dexp);
    chk("sel_done", 32'(DEV_Sel), 32'd0);
    @(negedge clk);
    chk("rdy_pulse", 32'(PrReady), 32'd0);
    chk("din_hold", PrDin, dexp);
  endtask
  task automatic stuck_slot2();
    int seen;
    PrReq = 1'b1; PrAddr = 32'h7F24; PrWe = 1'b0; PrDout = 32'h0;
    @(negedge clk);
    PrReq = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      chk("to_sel", 32'(DEV_Sel), 32'h4);
      chk("to_rdy_early", 32'(PrReady), 32'd0);
      DEV_Ack = 3'($urandom) & 3'b011;
      @(negedge clk);
    end
    DEV_Ack = '0;
    chk("to_rdy", 32'(PrReady), 32'd1);
    chk("to_err", 32'(PrErr), 32'd1);
    chk("to_din", PrDin, 32'd0);
    chk("to_sel_done", 32'(DEV_Sel), 32'd0);
    @(negedge clk);
    chk("to_rdy_pulse", 32'(PrReady), 32'd0);
`else
    seen = 0;
    repeat (100) begin
      DEV_Ack = 3'($urandom) & 3'b011;
      if (PrReady) seen++;
      @(negedge clk);
    end
    DEV_Ack = '0;
    chk("no_timeout_rdy", 32'(seen), 32'd0);
    chk("still_access", 32'(DEV_Sel), 32'h4);
    reset = 1'b1;
    #1 chk("stuck_reset_sel", 32'(DEV_Sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif
  endtask
  initial begin
    logic [2:0] irq;
    logic [31:0] addr;
    reset = 1'b1; PrReq = 1'b0; PrAddr = '0; PrWe = 1'b0; PrDout = '0;
    DEV_RD = '0; DEV_Ack = '0; DEV_IRQ = '0;
    repeat (2) @(negedge clk);
    chk("rst_din", PrDin, 32'd0);
    chk("rst_rdy", 32'(PrReady), 32'd0);
    chk("rst_err", 32'(PrErr), 32'd0);
    chk("rst_hwint", 32'(HWInt), 32'd0);
    chk("rst_addr", DEV_Addr, 32'd0);
    chk("rst_wd", DEV_WD, 32'd0);
    chk("rst_sel", 32'(DEV_Sel), 32'd0);
    chk("rst_we", 32'(DEV_We), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    access(32'h7F14, 1'b0, 32'h0, 32'hDEADBEEF, 0, 3'b101);
    access(32'h7F08, 1'b1, 32'h12345678, 32'hCAFEF00D, 3, 3'b000);
    access(32'h7F30, 1'b0, 32'h0, 32'h11111111, 0, 3'b000);
    access(32'h7EF0, 1'b1, 32'h5A5A5A5A, 32'h22222222, 0, 3'b000);
    access(32'h7F00, 1'b0, 32'h0, 32'h0BADCAFE, 2, 3'b110);
    access(32'h7F2F, 1'b0, 32'h0, 32'h33333333, 1, 3'b011);
    access(32'h7EFF, 1'b0, 32'h0, 32'h44444444, 0, 3'b000);
    access(32'hFFFF7F10, 1'b0, 32'h0, 32'h55555555, 0, 3'b000);
    stuck_slot2();
    DEV_IRQ = 3'b101;
    @(negedge clk);
    DEV_IRQ = 3'b000;
    chk("irq_on", 32'(HWInt), 32'h05);
    @(negedge clk);
    chk("irq_off", 32'(HWInt), 32'h00);
    repeat (6) begin
      irq = 3'($urandom);
      DEV_IRQ = irq;
      @(negedge clk);
      chk("irq_rand", 32'(HWInt), 32'(irq));
    end
    DEV_IRQ = '0;
    PrReq = 1'b1; PrAddr = 32'h7F04; PrWe = 1'b1; PrDout = 32'hA5A5A5A5;
    @(negedge clk);
    PrReq = 1'b0;
    @(negedge clk);
    chk("pre_reset_sel", 32'(DEV_Sel), 32'h1);
    reset = 1'b1;
    #1 chk("mid_reset_sel", 32'(DEV_Sel), 32'd0);
    chk("mid_reset_rdy", 32'(PrReady), 32'd0);
    @(negedge clk);
    DEV_Ack = 3'b001;
    reset = 1'b0;
    @(negedge clk);
    DEV_Ack = '0;
    repeat (2) begin
      chk("post_reset_rdy", 32'(PrReady), 32'd0);
      @(negedge clk);
    end
    access(32'h7F18, 1'b0, 32'h0, 32'h600DD00D, 1, 3'b000);
    repeat (40) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = 32'h7F00 + $urandom_range(0, 47);
        2:       addr = ($urandom_range(0, 1) != 0) ? 32'h7EF0 + $urandom_range(0, 15) : 32'h7F30 + $urandom_range(0, 255);
        default: addr = $urandom;
      endcase
      access(addr, 1'($urandom), $urandom, $urandom, $urandom_range(0, 2), 3'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
